rcu_adaptive: RTL and testbench

Parametrised, pipelined routing computation unit for one router of the 3D mesh. Serves NUM_IN input channels with independent valid/ready handshakes and picks an output port per header: dimension-ordered vertical first, partially adaptive in-plane using downstream credits. Faulty vertical links are debounced and detoured through a configured alternate elevator column. Sits between the input buffers and the switch allocator; produces one registered direction per channel.

---
 rtl/rcu_adaptive.sv | 191 +++++++++++++++++++
 tb/tb_rcu_adaptive.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcu_adaptive.sv
// rcu_adaptive: routing computation for one 3D mesh router, one registered
// decision per input channel. Define RCU_ADAPTIVE_EN for credit-based X/Y choice.
package rcu_adaptive_pkg;
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] z;
    } position_t;

    typedef enum logic [2:0] {
        NORTH = 3'd0,
        SOUTH = 3'd1,
        EAST  = 3'd2,
        WEST  = 3'd3,
        UP    = 3'd4,
        DOWN  = 3'd5,
        LOCAL = 3'd6
    } port_t;
endpackage

module rcu_adaptive
    import rcu_adaptive_pkg::*;
#(
    parameter position_t THIS_POS   = '{x: 4'd0, y: 4'd0, z: 4'd0},
    parameter int        NUM_IN     = 7,
    parameter int        CRED_W     = 4,
    parameter int        FAULT_HOLD = 4,
    parameter position_t ALT_ELEV   = '{x: 4'd0, y: 4'd0, z: 4'd0}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_IN-1:0]      req_valid,
    input  position_t [NUM_IN-1:0] req_dest,
    output logic [NUM_IN-1:0]      req_ready,
    output logic [NUM_IN-1:0]      dir_valid,
    output port_t [NUM_IN-1:0]     dir,
    input  logic [NUM_IN-1:0]      dir_ready,
    output logic [NUM_IN-1:0]      route_err,
    input  logic [5:0][CRED_W-1:0] credits,
    input  logic                   up_faulty,
    input  logic                   down_faulty,
    output logic                   up_fault_q,
    output logic                   down_fault_q
);

    localparam int CNT_W = $clog2(FAULT_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(FAULT_HOLD - 1);
    localparam logic ELEV_HERE = (ALT_ELEV.x == THIS_POS.x) &&
                                 (ALT_ELEV.y == THIS_POS.y);

    logic [NUM_IN-1:0]  dir_valid_q, dir_valid_d;
    port_t [NUM_IN-1:0] dir_q, dir_d;
    logic [NUM_IN-1:0]  err_q, err_d;
    logic [CNT_W-1:0]   up_cnt_q, up_cnt_d;
    logic [CNT_W-1:0]   dn_cnt_q, dn_cnt_d;
    logic               up_fault_d, down_fault_d;
`ifdef RCU_ADAPTIVE_EN
    logic [NUM_IN-1:0]  tie_q, tie_d;
`else
    logic               unused_credits;
    assign unused_credits = ^credits;
`endif

    assign req_ready = ~dir_valid_q | dir_ready;
    assign dir_valid = dir_valid_q;
    assign dir       = dir_q;
    assign route_err = err_q;

    // Debounce raw vertical faults: flip only after FAULT_HOLD differing samples
    always_comb begin
        up_fault_d   = up_fault_q;
        up_cnt_d     = '0;
        down_fault_d = down_fault_q;
        dn_cnt_d     = '0;
        if (up_faulty != up_fault_q) begin
            if (up_cnt_q == HOLD_LAST) begin
                up_fault_d = ~up_fault_q;
            end else begin
                up_cnt_d = up_cnt_q + 1'b1;
            end
        end
        if (down_faulty != down_fault_q) begin
            if (dn_cnt_q == HOLD_LAST) begin
                down_fault_d = ~down_fault_q;
            end else begin
                dn_cnt_d = dn_cnt_q + 1'b1;
            end
        end
    end

    // Route each channel's header and update its one-entry output register
    always_comb begin
        position_t  t;
        logic       need_up, need_dn, need_z;
        logic       has_x, has_y, use_y, e;
        logic [3:0] gx, gy;
        port_t      xp, yp, p;
`ifdef RCU_ADAPTIVE_EN
        logic       tied;
`endif
        dir_valid_d = dir_valid_q;
        dir_d       = dir_q;
        err_d       = err_q;
`ifdef RCU_ADAPTIVE_EN
        tie_d       = tie_q;
`endif
        for (int i = 0; i < NUM_IN; i++) begin
            t       = req_dest[i];
            need_up = t.z > THIS_POS.z;
            need_dn = t.z < THIS_POS.z;
            need_z  = need_up || need_dn;
            // A blocked vertical hop retargets the in-plane goal to the elevator
            gx      = need_z ? ALT_ELEV.x : t.x;
            gy      = need_z ? ALT_ELEV.y : t.y;
            has_x   = gx != THIS_POS.x;
            has_y   = gy != THIS_POS.y;
            xp      = (gx > THIS_POS.x) ? EAST : WEST;
            yp      = (gy > THIS_POS.y) ? NORTH : SOUTH;
            use_y   = !has_x;
`ifdef RCU_ADAPTIVE_EN
            tied    = 1'b0;
            if (has_x && has_y) begin
                if (credits[yp] > credits[xp]) begin
                    use_y = 1'b1;
                end else if (credits[xp] > credits[yp]) begin
                    use_y = 1'b0;
                end else begin
                    use_y = tie_q[i];
                    tied  = 1'b1;
                end
            end
`endif
            e = 1'b0;
            if (t == THIS_POS) begin
                p = LOCAL;
            end else if (need_up && !up_fault_q) begin
                p = UP;
            end else if (need_dn && !down_fault_q) begin
                p = DOWN;
            end else if (need_z && ELEV_HERE) begin
                p = LOCAL;
                e = 1'b1;
            end else begin
                p = use_y ? yp : xp;
            end

            if (req_valid[i] && req_ready[i]) begin
                dir_valid_d[i] = 1'b1;
                dir_d[i]       = p;
                err_d[i]       = e;
`ifdef RCU_ADAPTIVE_EN
                if (tied && !(p inside {UP, DOWN, LOCAL})) begin
                    tie_d[i] = ~tie_q[i];
                end
`endif
            end else if (dir_ready[i]) begin
                dir_valid_d[i] = 1'b0;
            end
        end
    end

    // Register state with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_valid_q  <= '0;
            err_q        <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                dir_q[i] <= LOCAL;
            end
            up_fault_q   <= 1'b0;
            down_fault_q <= 1'b0;
            up_cnt_q     <= '0;
            dn_cnt_q     <= '0;
`ifdef RCU_ADAPTIVE_EN
            tie_q        <= '0;
`endif
        end else begin
            dir_valid_q  <= dir_valid_d;
            err_q        <= err_d;
            dir_q        <= dir_d;
            up_fault_q   <= up_fault_d;
            down_fault_q <= down_fault_d;
            up_cnt_q     <= up_cnt_d;
            dn_cnt_q     <= dn_cnt_d;
`ifdef RCU_ADAPTIVE_EN
            tie_q        <= tie_d;
`endif
        end
    end

endmodule

// File: tb/tb_rcu_adaptive.sv
// tb_rcu_adaptive: scoreboard bench for rcu_adaptive, two instances that
// differ only in their detour elevator column.
module tb_rcu_adaptive;
    import rcu_adaptive_pkg::*;

    localparam int NUM_IN = 7;
    localparam int CRED_W = 4;
    localparam int FH     = 4;
    localparam int TX     = 1;
    localparam int TY     = 1;
    localparam int TZ     = 1;

    logic                   clk;
    logic                   reset;
    logic [NUM_IN-1:0]      req_valid;
    logic [NUM_IN-1:0]      dir_ready;
    position_t [NUM_IN-1:0] req_dest;
    logic [5:0][CRED_W-1:0] credits;
    logic                   up_faulty;
    logic                   down_faulty;

    logic [NUM_IN-1:0]      rr   [2];
    logic [NUM_IN-1:0]      dv   [2];
    logic [NUM_IN-1:0]      er   [2];
    port_t [NUM_IN-1:0]     dirs [2];
    logic                   fuq  [2];
    logic                   fdq  [2];

    int ntests = 0;
    int nfail  = 0;

    // reference model state
    logic [3:0] sbq [2][NUM_IN][$];
    bit         mv  [2][NUM_IN];
    bit         mfu, mfd;
    int         cu, cd;
`ifdef RCU_ADAPTIVE_EN
    bit         mtie [2][NUM_IN];
`endif

    rcu_adaptive #(
        .THIS_POS  ('{x: 4'd1, y: 4'd1, z: 4'd1}),
        .NUM_IN    (NUM_IN),
        .CRED_W    (CRED_W),
        .FAULT_HOLD(FH),
        .ALT_ELEV  ('{x: 4'd2, y: 4'd1, z: 4'd0})
    ) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_dest(req_dest), .req_ready(rr[0]),
        .dir_valid(dv[0]), .dir(dirs[0]), .dir_ready(dir_ready),
        .route_err(er[0]), .credits(credits),
        .up_faulty(up_faulty), .down_faulty(down_faulty),
        .up_fault_q(fuq[0]), .down_fault_q(fdq[0])
    );

    rcu_adaptive #(
        .THIS_POS  ('{x: 4'd1, y: 4'd1, z: 4'd1}),
        .NUM_IN    (NUM_IN),
        .CRED_W    (CRED_W),
        .FAULT_HOLD(FH),
        .ALT_ELEV  ('{x: 4'd1, y: 4'd1, z: 4'd0})
    ) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_dest(req_dest), .req_ready(rr[1]),
        .dir_valid(dv[1]), .dir(dirs[1]), .dir_ready(dir_ready),
        .route_err(er[1]), .credits(credits),
        .up_faulty(up_faulty), .down_faulty(down_faulty),
        .up_fault_q(fuq[1]), .down_fault_q(fdq[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int d, input int i,
                       input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s dut%0d ch%0d: got %0d, expected %0d",
                     nm, d, i, act, exp);
        end
    endtask

    // Expected {tie_used, err, port} for channel i of instance d
    function automatic logic [4:0] ref_route(input int d, input int i);
        int tx, ty, tz, gx, gy, ax, xc, yc, pick, cx, cy;
        bit tied;
        tx   = int'(req_dest[i].x);
        ty   = int'(req_dest[i].y);
        tz   = int'(req_dest[i].z);
        ax   = (d == 0) ? 2 : 1;
        gx   = tx;
        gy   = ty;
        tied = 1'b0;
        if (tx == TX && ty == TY && tz == TZ) return {2'b00, 3'(LOCAL)};
        if (tz > TZ && !mfu) return {2'b00, 3'(UP)};
        if (tz < TZ && !mfd) return {2'b00, 3'(DOWN)};
        if (tz != TZ) begin
            if (ax == TX) return {2'b01, 3'(LOCAL)};
            gx = ax;
            gy = 1;
        end
        xc = (gx > TX) ? int'(EAST) : (gx < TX) ? int'(WEST) : -1;
        yc = (gy > TY) ? int'(NORTH) : (gy < TY) ? int'(SOUTH) : -1;
        if (xc < 0) begin
            pick = yc;
        end else if (yc < 0) begin
            pick = xc;
        end else begin
            cx = int'(credits[3'(xc)]);
            cy = int'(credits[3'(yc)]);
`ifdef RCU_ADAPTIVE_EN
            if (cx > cy) begin
                pick = xc;
            end else if (cy > cx) begin
                pick = yc;
            end else begin
                tied = 1'b1;
                pick = mtie[d][i] ? yc : xc;
            end
`else
            pick = (cx >= 0 || cy >= 0) ? xc : xc;
`endif
        end
        return {tied, 1'b0, 3'(pick)};
    endfunction

    // Reference model: evaluate every accept at the clock edge
    initial begin
        logic [4:0] r;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int d = 0; d < 2; d++) begin
                    for (int i = 0; i < NUM_IN; i++) begin
                        mv[d][i] = 1'b0;
                        sbq[d][i].delete();
`ifdef RCU_ADAPTIVE_EN
                        mtie[d][i] = 1'b0;
`endif
                    end
                end
                mfu = 1'b0;
                mfd = 1'b0;
                cu  = 0;
                cd  = 0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    for (int i = 0; i < NUM_IN; i++) begin
                        if (req_valid[i] && (!mv[d][i] || dir_ready[i])) begin
                            r = ref_route(d, i);
                            sbq[d][i].push_back(r[3:0]);
                            mv[d][i] = 1'b1;
`ifdef RCU_ADAPTIVE_EN
                            if (r[4]) mtie[d][i] = !mtie[d][i];
`endif
                        end else if (dir_ready[i]) begin
                            mv[d][i] = 1'b0;
                        end
                    end
                end
                if (up_faulty != mfu) cu++; else cu = 0;
                if (cu == FH) begin mfu = !mfu; cu = 0; end
                if (down_faulty != mfd) cd++; else cd = 0;
                if (cd == FH) begin mfd = !mfd; cd = 0; end
            end
        end
    end

    // Monitor: compare DUT outputs against the model on the falling edge
    initial begin
        logic [3:0] f;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    chk("dir_valid", d, i, int'(dv[d][i]), int'(mv[d][i]));
                    chk("req_ready", d, i, int'(rr[d][i]),
                        int'(!mv[d][i] || dir_ready[i]));
                    if (dv[d][i]) begin
                        chk("sb_has_entry", d, i,
                            int'(sbq[d][i].size() > 0), 1);
                        if (sbq[d][i].size() > 0) begin
                            f = sbq[d][i][0];
                            chk("dir", d, i, int'(dirs[d][i]), int'(f[2:0]));
                            chk("route_err", d, i, int'(er[d][i]), int'(f[3]));
                            if (dir_ready[i]) void'(sbq[d][i].pop_front());
                        end
                    end
                end
                chk("up_fault_q", d, -1, int'(fuq[d]), int'(mfu));
                chk("down_fault_q", d, -1, int'(fdq[d]), int'(mfd));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int ch, input int x, input int y, input int z);
        req_valid     = '0;
        req_valid[ch] = 1'b1;
        req_dest[ch]  = '{x: 4'(x), y: 4'(y), z: 4'(z)};
        cyc(1);
        req_valid     = '0;
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        dir_ready   = '1;
        credits     = '0;
        up_faulty   = 1'b0;
        down_faulty = 1'b0;
        for (int i = 0; i < NUM_IN; i++) req_dest[i] = '{x: 4'd0, y: 4'd0, z: 4'd0};
        cyc(3);
        reset = 1'b0;
        cyc(1);

        // local delivery and in-plane credit choice
        send(0, 1, 1, 1);
        credits[2] = 4'd5; credits[0] = 4'd2; send(0, 3, 3, 1);
        credits[2] = 4'd2; credits[0] = 4'd5; send(0, 3, 3, 1);
        credits[2] = 4'd3; credits[0] = 4'd3; send(0, 3, 3, 1);
        send(0, 3, 3, 1);
        send(3, 0, 0, 1);
        cyc(2);

        // glitch shorter than the hold time, then a real fault
        up_faulty = 1'b1; cyc(3);
        up_faulty = 1'b0; cyc(1);
        send(0, 1, 1, 3);
        up_faulty = 1'b1; cyc(4);
        send(1, 1, 1, 3);
        send(1, 3, 0, 2);
        send(2, 1, 1, 0);
        cyc(2);

        // backpressure: hold decision while the next header waits
        dir_ready[2] = 1'b0;
        req_valid[2] = 1'b1;
        req_dest[2]  = '{x: 4'd0, y: 4'd1, z: 4'd1};
        cyc(1);
        req_dest[2]  = '{x: 4'd1, y: 4'd0, z: 4'd1};
        cyc(4);
        dir_ready[2] = 1'b1;
        cyc(1);
        req_valid    = '0;
        cyc(2);

        // randomized traffic with fault toggling
        for (int c = 0; c < 3000; c++) begin
            req_valid = NUM_IN'($urandom);
            dir_ready = NUM_IN'($urandom) | NUM_IN'($urandom);
            for (int i = 0; i < NUM_IN; i++) begin
                req_dest[i] = '{x: 4'($urandom_range(0, 3)),
                                y: 4'($urandom_range(0, 3)),
                                z: 4'($urandom_range(0, 2))};
            end
            for (int k = 0; k < 6; k++) credits[k] = CRED_W'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) up_faulty = !up_faulty;
            if ($urandom_range(0, 7) == 0) down_faulty = !down_faulty;
            cyc(1);
        end

        // reset in the middle of a stalled handshake with faults latched
        up_faulty   = 1'b1;
        down_faulty = 1'b1;
        req_valid   = '1;
        dir_ready   = '0;
        cyc(6);
        reset = 1'b1;
        cyc(1);
        reset     = 1'b0;
        req_valid = '0;
        dir_ready = '1;
        cyc(3);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                chk("sb_leftover", d, i, sbq[d][i].size(), 0);
            end
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
